// File: rtl/aes_mixcol_serial_if.sv
// aes_mixcol_serial_if
//   Handshake bundle between ShiftRows, the serial MixColumns stage and
//   AddRoundKey.
//   Upstream side:   in_valid, in_ready, in_last, in_state[16]
//   Downstream side: out_valid, out_ready, out_state[16]
//   Byte 4c+r of either state is row r of column c.
//   Modport master: the surrounding logic (ShiftRows source + AddRoundKey sink).
//   Modport slave:  the MixColumns stage.
interface aes_mixcol_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_last;
  logic [7:0] in_state [16];
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_state [16];

  modport master (
    output in_valid, in_last, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_last, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_mixcol_serial.sv
// aes_mixcol_serial
//   Column-serial AES MixColumns. One 32-bit column per cycle passes through a
//   single shared column multiplier; a final-round flag bypasses the multiply
//   while keeping the same 4-cycle latency.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : aes_mixcol_serial_if.slave (valid/ready in, valid/ready out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | buffer empty, ready to accept a block
//   BUSY  | transforming column r_col of the buffer, one column per cycle
//   DONE  | result held on out_state until out_ready; can reload same cycle
module aes_mixcol_serial (
  input  logic                 clk,
  input  logic                 rst,
  aes_mixcol_serial_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_buf [16];
  logic [1:0] r_col;
  logic       r_bypass;

  logic       w_in_ready;
  logic       w_out_valid;
  logic       w_accept;
  logic [7:0] w_col_in  [4];
  logic [7:0] w_col_out [4];

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Shared column multiplier, fed by the column selected with r_col.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_col_in[i] = r_buf[{r_col, i[1:0]}];
    end
    if (r_bypass) begin
      for (int i = 0; i < 4; i++) begin
        w_col_out[i] = w_col_in[i];
      end
    end else begin
      w_col_out[0] = xtime(w_col_in[0]) ^ xtime(w_col_in[1]) ^ w_col_in[1]
                   ^ w_col_in[2] ^ w_col_in[3];
      w_col_out[1] = w_col_in[0] ^ xtime(w_col_in[1]) ^ xtime(w_col_in[2])
                   ^ w_col_in[2] ^ w_col_in[3];
      w_col_out[2] = w_col_in[0] ^ w_col_in[1] ^ xtime(w_col_in[2])
                   ^ xtime(w_col_in[3]) ^ w_col_in[3];
      w_col_out[3] = xtime(w_col_in[0]) ^ w_col_in[0] ^ w_col_in[1]
                   ^ w_col_in[2] ^ xtime(w_col_in[3]);
    end
  end

  // Next state and handshake outputs. in_ready never looks at in_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (r_col == 2'd3) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_in_ready  = 1'b1;
          w_state_nxt = bus.in_valid ? S_BUSY : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept      = bus.in_valid && w_in_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_state = r_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_col    <= 2'd0;
      r_bypass <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= 8'h00;
      end
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_buf    <= bus.in_state;
        r_bypass <= bus.in_last;
        r_col    <= 2'd0;
      end else if (r_state == S_BUSY) begin
        for (int i = 0; i < 4; i++) begin
          r_buf[{r_col, i[1:0]}] <= w_col_out[i];
        end
        // col parks at 3 after the last column; only a new accept rewinds it.
        if (r_col != 2'd3) r_col <= r_col + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_mixcol_serial.sv
// tb_aes_mixcol_serial
//   Self-checking bench for aes_mixcol_serial. Expected results come from a
//   GF(2^8) matrix-multiply reference model and from published AES vectors.
module tb_aes_mixcol_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_mixcol_serial_if bus ();

  aes_mixcol_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [7:0] blk_t [16];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] s, input int j);
    return s[127-8*j -: 8];
  endfunction

  // State as a packed vector, byte 0 (row 0, column 0) in the top byte.
  function automatic logic [127:0] model(input logic [127:0] s, input logic last);
    logic [127:0] r;
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    if (last) return s;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef[(k - row + 4) % 4], byte_of(s, 4*c + k));
        end
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic blk_t to_blk(input logic [127:0] s);
    blk_t b;
    for (int j = 0; j < 16; j++) b[j] = s[127-8*j -: 8];
    return b;
  endfunction

  function automatic logic [127:0] from_blk(input blk_t b);
    logic [127:0] s;
    for (int j = 0; j < 16; j++) s[127-8*j -: 8] = b[j];
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a block, waits (bounded) for in_ready, and returns just after the
  // accept edge with in_valid dropped. waited >= 20 means it never got in.
  task automatic drive_block(input logic [127:0] s, input logic last, output int waited);
    bus.in_valid = 1'b1;
    bus.in_state = to_blk(s);
    bus.in_last  = last;
    #1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'($urandom);
    bus.in_state = to_blk(rnd128());
  endtask

  // Counts edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_last   = 1'b0;
    bus.in_state  = to_blk(rnd128());
    tick();
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    n_checks++;
    if (from_blk(bus.out_state) !== 128'h0) begin
      n_fail++; $display("FAIL reset_out_state: got %h expected 0", from_blk(bus.out_state));
    end
    begin
      bit seen = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (bus.out_valid !== 1'b0) seen = 1;
      end
      n_checks++;
      if (seen) begin
        n_fail++; $display("FAIL reset_no_accept: got out_valid=1 expected 0 throughout");
      end
    end
  endtask

  task automatic test_fips();
    logic [127:0] in_s = {32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    logic [127:0] exp  = {32'h046681e5, 32'he0cb199a, 32'h48f8d37a, 32'h2806264c};
    int w, lat;
    bus.out_ready = 1'b1;
    drive_block(in_s, 1'b0, w);
    wait_valid(lat);
    n_checks++;
    if (w >= 20 || lat != 4) begin
      n_fail++; $display("FAIL fips_latency: got wait=%0d lat=%0d expected 4", w, lat);
    end
    n_checks++;
    if (from_blk(bus.out_state) !== exp) begin
      n_fail++; $display("FAIL fips_state: got %h expected %h", from_blk(bus.out_state), exp);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL fips_valid_one_cycle: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_known_columns();
    logic [127:0] in_s = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
    logic [127:0] exp  = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
    int w, lat;
    bus.out_ready = 1'b1;
    drive_block(in_s, 1'b0, w);
    wait_valid(lat);
    n_checks++;
    if (w >= 20 || lat != 4) begin
      n_fail++; $display("FAIL known_latency: got wait=%0d lat=%0d expected 4", w, lat);
    end
    n_checks++;
    if (from_blk(bus.out_state) !== exp) begin
      n_fail++; $display("FAIL known_state: got %h expected %h", from_blk(bus.out_state), exp);
    end
    tick();
  endtask

  task automatic test_bypass();
    logic [127:0] in_s = {32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    int w, lat;
    bus.out_ready = 1'b1;
    drive_block(in_s, 1'b1, w);
    wait_valid(lat);
    n_checks++;
    if (w >= 20 || lat != 4) begin
      n_fail++; $display("FAIL bypass_latency: got wait=%0d lat=%0d expected 4", w, lat);
    end
    n_checks++;
    if (from_blk(bus.out_state) !== in_s) begin
      n_fail++; $display("FAIL bypass_state: got %h expected %h", from_blk(bus.out_state), in_s);
    end
    tick();
  endtask

  task automatic test_random();
    logic [127:0] s;
    logic         last;
    int w, lat, stall;
    for (int n = 0; n < 8; n++) begin
      s     = rnd128();
      last  = 1'($urandom_range(0, 3) == 0);
      stall = $urandom_range(0, 3);
      bus.out_ready = 1'b0;
      drive_block(s, last, w);
      wait_valid(lat);
      n_checks++;
      if (w >= 20 || lat != 4) begin
        n_fail++; $display("FAIL random_latency[%0d]: got wait=%0d lat=%0d expected 4", n, w, lat);
      end
      for (int k = 0; k < stall; k++) tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || from_blk(bus.out_state) !== model(s, last)) begin
        n_fail++;
        $display("FAIL random_state[%0d]: got v=%b %h expected v=1 %h", n, bus.out_valid,
                 from_blk(bus.out_state), model(s, last));
      end
      bus.out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] b1 = rnd128();
    logic [127:0] b2 = rnd128();
    int  w, lat;
    bit  bad = 0;
    bus.out_ready = 1'b0;
    drive_block(b1, 1'b0, w);
    wait_valid(lat);
    n_checks++;
    if (w >= 20 || lat != 4) begin
      n_fail++; $display("FAIL bp_latency: got wait=%0d lat=%0d expected 4", w, lat);
    end
    // Offer the second block during the stall; it must not be taken.
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_state = to_blk(b2);
    for (int k = 0; k < 7; k++) begin
      #1;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          from_blk(bus.out_state) !== model(b1, 1'b0)) begin
        bad = 1;
        $display("FAIL bp_stall[%0d]: got v=%b rdy=%b %h expected v=1 rdy=0 %h", k,
                 bus.out_valid, bus.in_ready, from_blk(bus.out_state), model(b1, 1'b0));
      end
      tick();
    end
    n_checks++;
    if (bad) n_fail++;
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_reload_busy: got out_valid=%b expected 0", bus.out_valid);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != 4) begin
      n_fail++; $display("FAIL bp_second_latency: got %0d expected 4", lat);
    end
    n_checks++;
    if (from_blk(bus.out_state) !== model(b2, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_second_state: got %h expected %h", from_blk(bus.out_state), model(b2, 1'b0));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] blks [4];
    logic         lasts [4];
    logic [127:0] expq [$];
    logic [127:0] e;
    int  idx = 0, nrecv = 0, last_t = -1;
    bit  acc;
    for (int i = 0; i < 4; i++) begin
      blks[i]  = rnd128();
      lasts[i] = 1'(i == 2);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_state  = to_blk(blks[0]);
    bus.in_last   = lasts[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        expq.push_back(model(blks[idx], lasts[idx]));
        idx++;
        if (idx < 4) begin
          bus.in_state = to_blk(blks[idx]);
          bus.in_last  = lasts[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid === 1'b1) begin
        e = (expq.size() > 0) ? expq.pop_front() : 128'hx;
        n_checks++;
        if (from_blk(bus.out_state) !== e) begin
          n_fail++; $display("FAIL b2b_state[%0d]: got %h expected %h", nrecv, from_blk(bus.out_state), e);
        end
        if (last_t >= 0) begin
          n_checks++;
          if (cyc - last_t != 5) begin
            n_fail++; $display("FAIL b2b_period[%0d]: got %0d expected 5", nrecv, cyc - last_t);
          end
        end
        last_t = cyc;
        nrecv++;
      end
    end
    n_checks++;
    if (nrecv != 4) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 4", nrecv);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] in_s = {4{32'h2d26314c}};
    logic [127:0] exp  = {4{32'h4d7ebdf8}};
    int  w, lat;
    bit  seen = 0;
    bus.out_ready = 1'b1;
    drive_block(rnd128(), 1'b0, w);
    tick();                       // now in the second BUSY cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || from_blk(bus.out_state) !== 128'h0) begin
      n_fail++;
      $display("FAIL midrst_cleared: got rdy=%b %h expected rdy=1 0", bus.in_ready,
               from_blk(bus.out_state));
    end
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid !== 1'b0) seen = 1;
      tick();
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL midrst_no_valid: got out_valid=1 expected 0 throughout");
    end
    drive_block(in_s, 1'b0, w);
    wait_valid(lat);
    n_checks++;
    if (w >= 20 || lat != 4) begin
      n_fail++; $display("FAIL midrst_next_latency: got wait=%0d lat=%0d expected 4", w, lat);
    end
    n_checks++;
    if (from_blk(bus.out_state) !== exp) begin
      n_fail++; $display("FAIL midrst_next_state: got %h expected %h", from_blk(bus.out_state), exp);
    end
    tick();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_state  = to_blk(128'h0);
    test_reset();
    test_fips();
    test_known_columns();
    test_bypass();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
